// File: rtl/prog_feeder.sv
// prog_feeder: host-side program/immediate feeder for the 8-bit CPU fetch bus.
// Serves instruction then immediate bytes from a small program memory, tracks
// the CPU phase, and captures the results the CPU presents in its OUTPUT state.
// Optional feature: define PROG_FEEDER_RESULT_FIFO_EN to buffer results in a
// FIFO_D-deep FIFO instead of a single overwrite-on-overrun register.
module prog_feeder #(
    parameter int ADDR_W = 6,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W:0]   prog_addr,
    input  logic [7:0]        prog_wdata,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              cpu_send_ins,
    input  logic              cpu_status,
    input  logic [7:0]        cpu_result,
    output logic [7:0]        cpu_data,
    output logic [1:0]        phase,
    output logic [7:0]        result,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              overrun,
    output logic              fault
);

    localparam int MEM_N = 2 ** (ADDR_W + 1);

    typedef enum logic [1:0] {
        PH_FETCH  = 2'b00,
        PH_DECODE = 2'b01,
        PH_WAIT   = 2'b10
    } phase_t;

    phase_t     r_phase;
    logic [7:0] r_mem [MEM_N];
    logic       r_fault;
    logic       r_overrun;
    logic       w_capture;

    // A legal result is presented; an illegal-instruction flag suppresses it.
    assign w_capture = cpu_send_ins & ~cpu_status;

    // Program memory: registered write, not cleared by reset so a program survives it.
    always_ff @(posedge clk) begin
        if (prog_we)
            r_mem[prog_addr] <= prog_wdata;
    end

    // Phase tracker: any send_ins restarts at FETCH, which also covers a skipped DECODE.
    always_ff @(posedge clk) begin
        if (rst)
            r_phase <= PH_FETCH;
        else if (cpu_send_ins)
            r_phase <= PH_FETCH;
        else begin
            case (r_phase)
                PH_FETCH:  r_phase <= PH_DECODE;
                PH_DECODE: r_phase <= PH_WAIT;
                default:   r_phase <= PH_WAIT;
            endcase
        end
    end

    // Byte presented to the CPU follows the current phase and the live PC.
    always_comb begin
        cpu_data = 8'h00;
        case (r_phase)
            PH_FETCH:  cpu_data = r_mem[{cpu_pc, 1'b0}];
            PH_DECODE: cpu_data = r_mem[{cpu_pc, 1'b1}];
            default:   cpu_data = 8'h00;
        endcase
    end

    // Sticky fault on any OUTPUT cycle flagged illegal.
    always_ff @(posedge clk) begin
        if (rst)
            r_fault <= 1'b0;
        else if (cpu_send_ins && cpu_status)
            r_fault <= 1'b1;
    end

`ifdef PROG_FEEDER_RESULT_FIFO_EN

    localparam int PTR_W = $clog2(FIFO_D);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_D[PTR_W:0];

    logic [7:0]       r_fifo [FIFO_D];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = result_ack & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_capture & (~w_full | w_pop);

    // FIFO storage: data only, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= cpu_result;
    end

    // FIFO pointers, occupancy and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_capture && !w_push)
                r_overrun <= 1'b1;
        end
    end

    assign result       = w_empty ? 8'h00 : r_fifo[r_rptr];
    assign result_valid = ~w_empty;

`else

    logic [7:0] r_result;
    logic       r_valid;

    // Single result register: newest capture always wins; losing an unread value is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            r_result <= cpu_result;
            r_valid  <= 1'b1;
            if (r_valid && !result_ack)
                r_overrun <= 1'b1;
        end else if (result_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;

`endif

    assign phase   = r_phase;
    assign overrun = r_overrun;
    assign fault   = r_fault;

endmodule

// File: tb/tb_prog_feeder.sv
// Self-checking bench for prog_feeder: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_prog_feeder;

    localparam int AW = 6;
    localparam int FD = 4;
`ifdef PROG_FEEDER_RESULT_FIFO_EN
    localparam int DEPTH = FD;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [AW:0] prog_addr;
    logic [7:0]  prog_wdata;
    logic [AW-1:0] cpu_pc;
    logic        cpu_send_ins;
    logic        cpu_status;
    logic [7:0]  cpu_result;
    logic [7:0]  cpu_data;
    logic [1:0]  phase;
    logic [7:0]  result;
    logic        result_valid;
    logic        result_ack;
    logic        overrun;
    logic        fault;

    always #5 clk = ~clk;

    prog_feeder #(.ADDR_W(AW), .FIFO_D(FD)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .cpu_pc(cpu_pc), .cpu_send_ins(cpu_send_ins),
        .cpu_status(cpu_status), .cpu_result(cpu_result), .cpu_data(cpu_data),
        .phase(phase), .result(result), .result_valid(result_valid),
        .result_ack(result_ack), .overrun(overrun), .fault(fault)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: phase from cycles elapsed since the last OUTPUT cycle,
    // results as a bounded queue.
    logic [7:0] mm [2**(AW+1)];
    int         since_out;
    logic [7:0] q[$];
    logic [7:0] last_res;
    bit         m_ovr, m_flt;

    function automatic int exp_phase();
        if (since_out == 0) return 0;
        if (since_out == 1) return 1;
        return 2;
    endfunction

    function automatic int exp_data();
        case (exp_phase())
            0: return int'(mm[{cpu_pc, 1'b0}]);
            1: return int'(mm[{cpu_pc, 1'b1}]);
            default: return 0;
        endcase
    endfunction

    function automatic int exp_result();
`ifdef PROG_FEEDER_RESULT_FIFO_EN
        return (q.size() > 0) ? int'(q[0]) : 0;
`else
        return int'(last_res);
`endif
    endfunction

    task automatic model_reset();
        since_out = 0;
        q.delete();
        last_res = 8'h00;
        m_ovr = 0;
        m_flt = 0;
    endtask

    task automatic model_step();
        if (prog_we) mm[prog_addr] = prog_wdata;
        if (rst) begin
            model_reset();
            return;
        end
        since_out = cpu_send_ins ? 0 : ((since_out < 2) ? since_out + 1 : 2);
        if (cpu_send_ins && cpu_status) m_flt = 1;
        if (result_ack && q.size() > 0) void'(q.pop_front());
        if (cpu_send_ins && !cpu_status) begin
            if (q.size() < DEPTH) begin
                q.push_back(cpu_result);
                last_res = cpu_result;
            end else begin
                m_ovr = 1;
`ifndef PROG_FEEDER_RESULT_FIFO_EN
                q[0] = cpu_result;
                last_res = cpu_result;
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("phase", int'(phase), exp_phase());
        chk("cpu_data", int'(cpu_data), exp_data());
        chk("result", int'(result), exp_result());
        chk("result_valid", int'(result_valid), int'(q.size() > 0));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("fault", int'(fault), int'(m_flt));
    endtask

    // Called just after a negedge with inputs set: compare, advance model, advance DUT.
    task automatic tick();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
        cpu_send_ins = 0; cpu_status = 0; cpu_result = '0; result_ack = 0;
    endtask

    initial begin
        idle_inputs();
        cpu_pc = '0;
        rst = 1;
        // Load the whole program memory while held in reset.
        @(negedge clk);
        for (int a = 0; a < 2**(AW+1); a++) begin
            prog_we = 1;
            prog_addr = a[AW:0];
            prog_wdata = (a == 0) ? 8'h11 : (a == 1) ? 8'hA5 : 8'($urandom);
            mm[a] = prog_wdata;
            @(negedge clk);
        end
        prog_we = 0;
        @(negedge clk);
        model_reset();
        rst = 0;

        // Reset state and test 1: FETCH / DECODE / WAIT bytes.
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("t1_fetch", int'(cpu_data), 8'h11);
        tick();
        #1 chk("t1_decode", int'(cpu_data), 8'hA5);
        tick();
        #1 chk("t1_wait", int'(cpu_data), 8'h00);
        chk("t1_phase_wait", int'(phase), 2);
        tick();

        // Test 2: capture in WAIT.
        cpu_send_ins = 1; cpu_result = 8'h3C;
        tick();
        cpu_send_ins = 0;
        #1 chk("t2_result", int'(result), 8'h3C);
        chk("t2_valid", int'(result_valid), 1);
        chk("t2_phase", int'(phase), 0);
        tick();

        // Test 3: illegal instruction flagged in DECODE.
        cpu_send_ins = 1; cpu_status = 1;
        tick();
        cpu_send_ins = 0; cpu_status = 0;
        #1 chk("t3_fault", int'(fault), 1);
        chk("t3_valid", int'(result_valid), 1);
        chk("t3_phase", int'(phase), 0);

`ifndef PROG_FEEDER_RESULT_FIFO_EN
        // Test 4: overwrite without ack flags overrun; with ack it does not.
        rst = 1; tick(); rst = 0;
        cpu_send_ins = 1; cpu_result = 8'h01; tick();
        cpu_result = 8'h02; tick();
        cpu_send_ins = 0;
        #1 chk("t4_result", int'(result), 8'h02);
        chk("t4_overrun", int'(overrun), 1);
        rst = 1; tick(); rst = 0;
        cpu_send_ins = 1; cpu_result = 8'h01; tick();
        cpu_result = 8'h02; result_ack = 1; tick();
        cpu_send_ins = 0; result_ack = 0;
        #1 chk("t4_ack_result", int'(result), 8'h02);
        chk("t4_ack_valid", int'(result_valid), 1);
        chk("t4_ack_overrun", int'(overrun), 0);
        tick();
`else
        // Test 5: FIFO fill, drop on full, drain; then push+pop while full.
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_send_ins = 1; cpu_result = 8'h10 + 8'(i); tick();
        end
        cpu_send_ins = 0;
        #1 chk("t5_overrun", int'(overrun), 1);
        for (int i = 0; i < 4; i++) begin
            result_ack = 1;
            #1 chk("t5_pop", int'(result), 8'h10 + i);
            tick();
        end
        result_ack = 0;
        #1 chk("t5_empty", int'(result_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cpu_send_ins = 1; cpu_result = 8'h20 + 8'(i); tick();
        end
        cpu_result = 8'h24; result_ack = 1; tick();
        cpu_send_ins = 0;
        for (int i = 1; i < 5; i++) begin
            result_ack = 1;
            #1 chk("t5_full_pop", int'(result), 8'h20 + i);
            tick();
        end
        result_ack = 0;
        #1 chk("t5_drained", int'(result_valid), 0);
        tick();
`endif

        // Test 6: reset in DECODE with valid result and sticky flags set.
        cpu_send_ins = 1; cpu_status = 1; tick();
        cpu_status = 0; cpu_result = 8'h77; tick();
        cpu_send_ins = 0; tick();
        #1 chk("t6_pre_phase", int'(phase), 1);
        chk("t6_pre_valid", int'(result_valid), 1);
        rst = 1; tick(); rst = 0;
        cpu_pc = '0;
        #1 chk("t6_phase", int'(phase), 0);
        chk("t6_valid", int'(result_valid), 0);
        chk("t6_fault", int'(fault), 0);
        chk("t6_overrun", int'(overrun), 0);
        chk("t6_mem", int'(cpu_data), 8'h11);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(63) == 0);
            prog_we      = ($urandom_range(3) == 0);
            prog_addr    = 7'($urandom);
            prog_wdata   = 8'($urandom);
            cpu_pc       = 6'($urandom);
            cpu_send_ins = ($urandom_range(3) == 0);
            cpu_status   = ($urandom_range(7) == 0);
            cpu_result   = 8'($urandom);
            result_ack   = ($urandom_range(2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
